// File: rtl/two_digit_entry_ctrl.sv
// Two-digit BCD keypad entry sequencer: gathers up to two digits and hands the
// joined binary value (tens*10 + ones) downstream over a valid/ready handshake.
module two_digit_entry_ctrl #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] dig_tens,
  output logic [3:0] dig_ones,
  output logic [1:0] digit_count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_value,
  output logic       err
);

  localparam int unsigned CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned VAL_W     = 7;
  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam logic [3:0]  KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_TWO, S_HOLD} state_t;

  state_t           state, state_d;
  logic [3:0]       tens_d, ones_d;
  logic [1:0]       count_d;
  logic [VAL_W-1:0] value_d;
  logic             err_d;
  logic [CNT_W-1:0] tmo_cnt, tmo_d;

  logic             accept_c;
  logic             is_digit_c;
  logic             tmo_hit_c;
  logic [VAL_W-1:0] joined_c;

  assign accept_c   = key_valid && key_ready;
  assign is_digit_c = (key_code < KEY_CLEAR);
  assign tmo_hit_c  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign joined_c   = VAL_W'(dig_tens) * VAL_W'(10) + VAL_W'(dig_ones);

  // Next-state and next-output logic; the counter defaults to 0 so any
  // accepted key or state change clears it.
  always_comb begin
    state_d = state;
    tens_d  = dig_tens;
    ones_d  = dig_ones;
    count_d = digit_count;
    value_d = out_value;
    err_d   = 1'b0;
    tmo_d   = '0;

    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (is_digit_c) begin
            state_d = S_ONE;
            tens_d  = 4'd0;
            ones_d  = key_code;
            count_d = 2'd1;
          end else if (key_code == KEY_ENTER) begin
            err_d = 1'b1;
          end
        end
      end

      S_ONE, S_TWO: begin
        if (accept_c) begin
          if (is_digit_c) begin
            if (state == S_ONE) begin
              state_d = S_TWO;
              tens_d  = dig_ones;
              ones_d  = key_code;
              count_d = 2'd2;
            end else begin
              err_d = 1'b1;
            end
          end else if (key_code == KEY_ENTER) begin
            state_d = S_HOLD;
            value_d = joined_c;
          end else if (key_code == KEY_CLEAR) begin
            state_d = S_IDLE;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            count_d = 2'd0;
          end
        end else if (tmo_hit_c) begin
          state_d = S_IDLE;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          count_d = 2'd0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_cnt + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          count_d = 2'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      key_ready   <= 1'b1;
      out_valid   <= 1'b0;
      out_value   <= '0;
      dig_tens    <= 4'd0;
      dig_ones    <= 4'd0;
      digit_count <= 2'd0;
      err         <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_d;
      key_ready   <= (state_d != S_HOLD);
      out_valid   <= (state_d == S_HOLD);
      out_value   <= value_d;
      dig_tens    <= tens_d;
      dig_ones    <= ones_d;
      digit_count <= count_d;
      err         <= err_d;
      tmo_cnt     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_two_digit_entry_ctrl.sv
// Directed bench for two_digit_entry_ctrl; joined values go through a scoreboard
// queue that a negedge monitor drains on every completed handshake.
module tb_two_digit_entry_ctrl;

  localparam int unsigned TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] dig_tens;
  logic [3:0] dig_ones;
  logic [1:0] digit_count;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_value;
  logic       err;

  int errors = 0;
  int checks = 0;
  int unsigned sb[$];

  two_digit_entry_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .dig_tens(dig_tens), .dig_ones(dig_ones),
    .digit_count(digit_count), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  // Scoreboard: each handshake seen before the next edge must match the oldest pushed value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'(out_value), 32'hFFFF_FFFF);
      end else begin
        chk("sb_out_value", 32'(out_value), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;
    tick();
    chk("rst_key_ready", 32'(key_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_value", 32'(out_value), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // 2, 6, ENTER with consumer ready
    out_ready = 1'b1;
    key(4'd2);
    chk("t1_count1", 32'(digit_count), 1);
    chk("t1_ones1", 32'(dig_ones), 2);
    key(4'd6);
    chk("t1_tens", 32'(dig_tens), 2);
    chk("t1_ones", 32'(dig_ones), 6);
    chk("t1_count2", 32'(digit_count), 2);
    sb.push_back(26);
    key(4'hB);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_value", 32'(out_value), 26);
    chk("t1_key_ready_hold", 32'(key_ready), 0);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 0);
    chk("t1_count0", 32'(digit_count), 0);
    chk("t1_key_ready", 32'(key_ready), 1);

    // 7, ENTER, consumer stalls while keys 3 and 4 are dropped
    out_ready = 1'b0;
    key(4'd7);
    sb.push_back(7);
    key(4'hB);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", 32'(out_valid), 1);
      chk("t2_value_held", 32'(out_value), 7);
      chk("t2_ones_held", 32'(dig_ones), 7);
      chk("t2_count_held", 32'(digit_count), 1);
      key_valid = (i == 1 || i == 2);
      key_code  = (i == 1) ? 4'd3 : 4'd4;
      tick();
    end
    key_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t2_valid_done", 32'(out_valid), 0);
    chk("t2_key_ready", 32'(key_ready), 1);
    chk("t2_count0", 32'(digit_count), 0);

    // 9, 9, 5 -> third digit rejected, then ENTER gives 99
    out_ready = 1'b0;
    key(4'd9);
    key(4'd9);
    chk("t3_no_err", 32'(err), 0);
    key(4'd5);
    chk("t3_err", 32'(err), 1);
    chk("t3_tens", 32'(dig_tens), 9);
    chk("t3_ones", 32'(dig_ones), 9);
    chk("t3_count", 32'(digit_count), 2);
    tick();
    chk("t3_err_pulse", 32'(err), 0);
    out_ready = 1'b1;
    sb.push_back(99);
    key(4'hB);
    chk("t3_value", 32'(out_value), 99);
    chk("t3_valid", 32'(out_valid), 1);
    tick();
    chk("t3_valid_done", 32'(out_valid), 0);

    // ENTER in IDLE, then 4, CLEAR
    key(4'hB);
    chk("t4_err", 32'(err), 1);
    chk("t4_valid", 32'(out_valid), 0);
    tick();
    chk("t4_err_pulse", 32'(err), 0);
    key(4'd4);
    chk("t4_count1", 32'(digit_count), 1);
    key(4'hA);
    chk("t4_count0", 32'(digit_count), 0);
    chk("t4_ones0", 32'(dig_ones), 0);
    chk("t4_no_err", 32'(err), 0);

    // Timeout fires on the TMO-th idle edge
    key(4'd5);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("t5_no_early_tmo", 32'(err), 0);
    end
    chk("t5_count_pre", 32'(digit_count), 1);
    tick();
    chk("t5_tmo_err", 32'(err), 1);
    chk("t5_tmo_count", 32'(digit_count), 0);
    chk("t5_tmo_ones", 32'(dig_ones), 0);
    tick();
    chk("t5_err_pulse", 32'(err), 0);

    // A key on the TMO-th edge wins, and restarts the count from there
    key(4'd5);
    for (int i = 1; i < TMO; i++) tick();
    key(4'd3);
    chk("t5_key_wins_err", 32'(err), 0);
    chk("t5_key_wins_count", 32'(digit_count), 2);
    chk("t5_key_wins_tens", 32'(dig_tens), 5);
    chk("t5_key_wins_ones", 32'(dig_ones), 3);
    for (int i = 1; i < TMO; i++) tick();
    chk("t5_restart_no_err", 32'(err), 0);
    tick();
    chk("t5_restart_err", 32'(err), 1);
    chk("t5_restart_count", 32'(digit_count), 0);

    // Reset while a value is pending
    out_ready = 1'b0;
    key(4'd1);
    key(4'd2);
    key(4'hB);
    chk("t6_valid", 32'(out_valid), 1);
    chk("t6_value", 32'(out_value), 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_value", 32'(out_value), 0);
    chk("t6_rst_tens", 32'(dig_tens), 0);
    chk("t6_rst_ones", 32'(dig_ones), 0);
    chk("t6_rst_key_ready", 32'(key_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    key(4'd3);
    chk("t6_idle_after_rst", 32'(digit_count), 1);
    chk("t6_ones_after_rst", 32'(dig_ones), 3);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
